// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control unit: latches the fetched instruction and sequences IF/ID/EX/MEM/WB.
// Optional performance counters (cycle_cnt, instret) are compiled in with MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_data,
    input  logic        Zero,
    output logic [31:0] instr,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [3:0]  ALUCtrl,
    output logic        loadPC,
    output logic [2:0]  state,
    output logic        illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
`endif
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        K_R   = 3'd0,
        K_I   = 3'd1,
        K_LW  = 3'd2,
        K_SW  = 3'd3,
        K_BR  = 3'd4,
        K_BAD = 3'd5
    } kind_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    // Returns {legal, alu_op}; only funct7 of 0000000 or 0100000 (SUB/SRA) is accepted.
    function automatic logic [4:0] decode_r(input logic [6:0] funct7, input logic [2:0] funct3);
        logic [4:0] res;
        res = {1'b0, ALU_AND};
        if (funct7 == 7'b0000000) begin
            case (funct3)
                3'b000:  res = {1'b1, ALU_ADD};
                3'b001:  res = {1'b1, ALU_SLL};
                3'b010:  res = {1'b1, ALU_SLT};
                3'b100:  res = {1'b1, ALU_XOR};
                3'b101:  res = {1'b1, ALU_SRL};
                3'b110:  res = {1'b1, ALU_OR};
                3'b111:  res = {1'b1, ALU_AND};
                default: res = {1'b0, ALU_AND};
            endcase
        end else if (funct7 == 7'b0100000) begin
            case (funct3)
                3'b000:  res = {1'b1, ALU_SUB};
                3'b101:  res = {1'b1, ALU_SRA};
                default: res = {1'b0, ALU_AND};
            endcase
        end else begin
            res = {1'b0, ALU_AND};
        end
        return res;
    endfunction

    function automatic logic [4:0] decode_i(input logic [2:0] funct3, input logic bit30);
        logic [4:0] res;
        case (funct3)
            3'b000:  res = {1'b1, ALU_ADD};
            3'b001:  res = {1'b1, ALU_SLL};
            3'b010:  res = {1'b1, ALU_SLT};
            3'b100:  res = {1'b1, ALU_XOR};
            3'b101:  res = bit30 ? {1'b1, ALU_SRA} : {1'b1, ALU_SRL};
            3'b110:  res = {1'b1, ALU_OR};
            3'b111:  res = {1'b1, ALU_AND};
            default: res = {1'b0, ALU_AND};
        endcase
        return res;
    endfunction

    state_e      state_r;
    state_e      state_nxt_s;
    logic [31:0] instr_r;
    kind_e       kind_s;
    logic [3:0]  alu_s;
    logic [4:0]  dec_s;
    logic        pcsrc_s, alusrc_s, regwrite_s, memtoreg_s, memread_s, memwrite_s, loadpc_s, illegal_s;
    logic [3:0]  aluctrl_s;

    // State register and instruction register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IF;
            instr_r <= NOP_INSTR;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_IF) begin
                instr_r <= imem_data;
            end
        end
    end

    // Instruction class and ALU operation decode
    always_comb begin
        kind_s = K_BAD;
        alu_s  = ALU_AND;
        dec_s  = 5'b00000;
        case (instr_r[6:0])
            OP_R: begin
                dec_s  = decode_r(instr_r[31:25], instr_r[14:12]);
                kind_s = dec_s[4] ? K_R : K_BAD;
                alu_s  = dec_s[4] ? dec_s[3:0] : ALU_AND;
            end
            OP_I: begin
                dec_s  = decode_i(instr_r[14:12], instr_r[30]);
                kind_s = dec_s[4] ? K_I : K_BAD;
                alu_s  = dec_s[4] ? dec_s[3:0] : ALU_AND;
            end
            OP_LOAD: begin
                kind_s = (instr_r[14:12] == 3'b010) ? K_LW : K_BAD;
                alu_s  = (instr_r[14:12] == 3'b010) ? ALU_ADD : ALU_AND;
            end
            OP_STORE: begin
                kind_s = (instr_r[14:12] == 3'b010) ? K_SW : K_BAD;
                alu_s  = (instr_r[14:12] == 3'b010) ? ALU_ADD : ALU_AND;
            end
            OP_BR: begin
                kind_s = (instr_r[14:13] == 2'b00) ? K_BR : K_BAD;
                alu_s  = (instr_r[14:13] == 2'b00) ? ALU_SUB : ALU_AND;
            end
            default: begin
                kind_s = K_BAD;
                alu_s  = ALU_AND;
            end
        endcase
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_nxt_s = S_IF;
        pcsrc_s     = 1'b0;
        alusrc_s    = 1'b0;
        regwrite_s  = 1'b0;
        memtoreg_s  = 1'b0;
        memread_s   = 1'b0;
        memwrite_s  = 1'b0;
        loadpc_s    = 1'b0;
        illegal_s   = 1'b0;
        aluctrl_s   = ALU_AND;
        case (state_r)
            S_IF: state_nxt_s = S_ID;
            S_ID: state_nxt_s = S_EX;
            S_EX: begin
                case (kind_s)
                    K_R: begin
                        aluctrl_s   = alu_s;
                        state_nxt_s = S_WB;
                    end
                    K_I: begin
                        alusrc_s    = 1'b1;
                        aluctrl_s   = alu_s;
                        state_nxt_s = S_WB;
                    end
                    K_LW, K_SW: begin
                        alusrc_s    = 1'b1;
                        aluctrl_s   = ALU_ADD;
                        state_nxt_s = S_MEM;
                    end
                    K_BR: begin
                        // funct3[0] distinguishes BNE from BEQ
                        aluctrl_s   = ALU_SUB;
                        loadpc_s    = 1'b1;
                        pcsrc_s     = instr_r[12] ? ~Zero : Zero;
                        state_nxt_s = S_IF;
                    end
                    default: begin
                        illegal_s   = 1'b1;
                        loadpc_s    = 1'b1;
                        state_nxt_s = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                alusrc_s  = 1'b1;
                aluctrl_s = ALU_ADD;
                if (kind_s == K_LW) begin
                    memread_s   = 1'b1;
                    state_nxt_s = S_WB;
                end else if (kind_s == K_SW) begin
                    memwrite_s  = 1'b1;
                    loadpc_s    = 1'b1;
                    state_nxt_s = S_IF;
                end else begin
                    state_nxt_s = S_IF;
                end
            end
            S_WB: begin
                // ALU inputs held from EX so the write-back value stays stable
                regwrite_s  = 1'b1;
                loadpc_s    = 1'b1;
                memtoreg_s  = (kind_s == K_LW);
                alusrc_s    = (kind_s != K_R);
                aluctrl_s   = alu_s;
                state_nxt_s = S_IF;
            end
            default: state_nxt_s = S_IF;
        endcase
    end

    // Reset forces every strobe low so an aborted instruction never writes or retires
    assign PCSrc    = rst & pcsrc_s;
    assign ALUSrc   = rst & alusrc_s;
    assign RegWrite = rst & regwrite_s;
    assign MemToReg = rst & memtoreg_s;
    assign MemRead  = rst & memread_s;
    assign MemWrite = rst & memwrite_s;
    assign loadPC   = rst & loadpc_s;
    assign illegal  = rst & illegal_s;
    assign ALUCtrl  = rst ? aluctrl_s : 4'b0000;
    assign instr    = instr_r;
    assign state    = state_r;

`ifdef MULTICYCLE_CTRL_PERF_EN
    // Free-running cycle counter and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (loadpc_s && !illegal_s) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table plus latency/corner sequences.
module tb_multicycle_ctrl;

    localparam logic [31:0] I_NOP  = 32'h00000013;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_SUB  = 32'h40208133;
    localparam logic [31:0] I_LW   = 32'h0000a183;
    localparam logic [31:0] I_SW   = 32'h0030a223;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_data;
    logic        Zero;
    logic [31:0] instr;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, loadPC, illegal;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret;
`endif

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .imem_data(imem_data), .Zero(Zero), .instr(instr),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUCtrl(ALUCtrl), .loadPC(loadPC),
        .state(state), .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] imem;
        logic        zero;
        logic [2:0]  st;
        logic [31:0] ins;
        logic [11:0] ctrl;  // {PCSrc,ALUSrc,RegWrite,MemToReg,MemRead,MemWrite,ALUCtrl[3:0],loadPC,illegal}
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [31:0] im, input logic z,
                       input logic [2:0] st, input logic [31:0] ins, input logic [11:0] c);
        vec_t v;
        v.rst = r; v.imem = im; v.zero = z; v.st = st; v.ins = ins; v.ctrl = c;
        vecs.push_back(v);
    endtask

    // Runs one instruction from IF until its loadPC pulse and checks latency and key strobes
    task automatic run_instr(input string nm, input logic [31:0] im, input logic z, input int exp_lat,
                             input logic [3:0] exp_alu, input logic exp_ill, input logic exp_rw);
        int         lat;
        logic [3:0] alu_at;
        logic       ill_seen, rw_seen, done;
        lat = 0; alu_at = 4'h0; ill_seen = 1'b0; rw_seen = 1'b0; done = 1'b0;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            imem_data = (c == 1) ? im : 32'h00000000;
            Zero = z;
            #1;
            if (c == 1) chk({nm, " start_state"}, 32'(state), 32'd0);
            chk({nm, " strobe_excl"},
                32'((RegWrite & MemRead) | (RegWrite & MemWrite) | (MemRead & MemWrite)), 32'd0);
            if (RegWrite) rw_seen = 1'b1;
            if (illegal) ill_seen = 1'b1;
            if (loadPC) begin
                lat = c;
                alu_at = ALUCtrl;
                done = 1'b1;
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " alu"}, 32'(alu_at), 32'(exp_alu));
        chk({nm, " illegal"}, 32'(ill_seen), 32'(exp_ill));
        chk({nm, " regwrite"}, 32'(rw_seen), 32'(exp_rw));
    endtask

    initial begin
        rst = 1'b0; imem_data = 32'h0; Zero = 1'b0;
        repeat (2) @(posedge clk);

        // reset held, then ADDI
        add(1'b0, 32'h0,  1'b0, 3'd0, I_NOP,  12'b0000_00_0000_00);
        add(1'b1, I_ADDI, 1'b0, 3'd0, I_NOP,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd1, I_ADDI, 12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd2, I_ADDI, 12'b0100_00_0010_00);
        add(1'b1, 32'h0,  1'b0, 3'd4, I_ADDI, 12'b0110_00_0010_10);
        // SUB
        add(1'b1, I_SUB,  1'b0, 3'd0, I_ADDI, 12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd1, I_SUB,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd2, I_SUB,  12'b0000_00_0110_00);
        add(1'b1, 32'h0,  1'b0, 3'd4, I_SUB,  12'b0010_00_0110_10);
        // LW
        add(1'b1, I_LW,   1'b0, 3'd0, I_SUB,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd1, I_LW,   12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd2, I_LW,   12'b0100_00_0010_00);
        add(1'b1, 32'h0,  1'b0, 3'd3, I_LW,   12'b0100_10_0010_00);
        add(1'b1, 32'h0,  1'b0, 3'd4, I_LW,   12'b0111_00_0010_10);
        // SW
        add(1'b1, I_SW,   1'b0, 3'd0, I_LW,   12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd1, I_SW,   12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd2, I_SW,   12'b0100_00_0010_00);
        add(1'b1, 32'h0,  1'b0, 3'd3, I_SW,   12'b0100_01_0010_10);
        // BEQ taken, BEQ not taken, BNE taken
        add(1'b1, I_BEQ,  1'b0, 3'd0, I_SW,   12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd1, I_BEQ,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b1, 3'd2, I_BEQ,  12'b1000_00_0110_10);
        add(1'b1, I_BEQ,  1'b0, 3'd0, I_BEQ,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd1, I_BEQ,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd2, I_BEQ,  12'b0000_00_0110_10);
        add(1'b1, I_BNE,  1'b0, 3'd0, I_BEQ,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd1, I_BNE,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd2, I_BNE,  12'b1000_00_0110_10);
        // illegal opcode
        add(1'b1, I_BAD,  1'b0, 3'd0, I_BNE,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd1, I_BAD,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd2, I_BAD,  12'b0000_00_0000_11);
        // SW aborted by reset in MEM, then ADDI restarts cleanly
        add(1'b1, I_SW,   1'b0, 3'd0, I_BAD,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd1, I_SW,   12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd2, I_SW,   12'b0100_00_0010_00);
        add(1'b0, 32'h0,  1'b0, 3'd3, I_SW,   12'b0000_00_0000_00);
        add(1'b1, I_ADDI, 1'b0, 3'd0, I_NOP,  12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd1, I_ADDI, 12'b0000_00_0000_00);
        add(1'b1, 32'h0,  1'b0, 3'd2, I_ADDI, 12'b0100_00_0010_00);
        add(1'b1, 32'h0,  1'b0, 3'd4, I_ADDI, 12'b0110_00_0010_10);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            imem_data = vecs[i].imem;
            Zero = vecs[i].zero;
            #1;
            chk($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d instr", i), instr, vecs[i].ins);
            chk($sformatf("v%0d ctrl", i),
                32'({PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, ALUCtrl, loadPC, illegal}),
                32'(vecs[i].ctrl));
        end

        // latency and decode corner cases
        run_instr("and",      32'h0020F1B3, 1'b0, 4, 4'b0000, 1'b0, 1'b1);
        run_instr("srai",     32'h4010D093, 1'b0, 4, 4'b1010, 1'b0, 1'b1);
        run_instr("add_x0",   32'h00000033, 1'b0, 4, 4'b0010, 1'b0, 1'b1);
        run_instr("lw",       I_LW,         1'b0, 5, 4'b0010, 1'b0, 1'b1);
        run_instr("sw",       I_SW,         1'b0, 4, 4'b0010, 1'b0, 1'b0);
        run_instr("beq",      I_BEQ,        1'b1, 3, 4'b0110, 1'b0, 1'b0);
        run_instr("sltu_bad", 32'h0020B1B3, 1'b0, 3, 4'b0000, 1'b1, 1'b0);
        run_instr("br_f3bad", 32'h0020A463, 1'b0, 3, 4'b0000, 1'b1, 1'b0);

        // PCSrc follows Zero combinationally during a BNE EX cycle
        @(negedge clk); imem_data = I_BNE; Zero = 1'b0;
        @(negedge clk); imem_data = 32'h0;
        @(negedge clk); Zero = 1'b1; #1;
        chk("bne_ex state", 32'(state), 32'd2);
        chk("bne_zero1 pcsrc", 32'(PCSrc), 32'd0);
        Zero = 1'b0; #1;
        chk("bne_zero0 pcsrc", 32'(PCSrc), 32'd1);
        chk("bne loadpc", 32'(loadPC), 32'd1);

`ifdef MULTICYCLE_CTRL_PERF_EN
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1; imem_data = I_ADDI; #1;
        chk("perf cycle_cnt_rst", cycle_cnt, 32'd0);
        chk("perf instret_rst", instret, 32'd0);
        repeat (4) begin
            @(negedge clk);
            imem_data = I_NOP;
        end
        #1;
        chk("perf cycle_cnt", cycle_cnt, 32'd4);
        chk("perf instret", instret, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
